// File: rtl/cg_mem_arb_pkg.sv
// rtl/cg_mem_arb_pkg.sv - shared types for the two-requester memory arbiter
package cg_mem_arb_pkg;
   localparam int NUM_REQ = 2;

   typedef enum logic {
      ARB_IDLE = 1'b0,
      ARB_HOLD = 1'b1
   } arb_state_e;

   typedef logic [$clog2(NUM_REQ)-1:0] req_id_t;
endpackage

// File: rtl/cg_mem_arb_tag_fifo.sv
// rtl/cg_mem_arb_tag_fifo.sv - in-order requester-id FIFO for outstanding reads
// A push into a full FIFO is taken only when a pop happens in the same cycle.
module cg_mem_arb_tag_fifo #(
   parameter int DEPTH = 4,
   parameter int WIDTH = 1
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             push,
   input  logic [WIDTH-1:0] push_data,
   input  logic             pop,
   output logic             full,
   output logic             empty,
   output logic [WIDTH-1:0] head
);
   localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
   localparam logic [AW:0] FULL_CNT = (AW+1)'(DEPTH);

   logic [WIDTH-1:0] mem [DEPTH];
   logic [AW-1:0]    wr_ptr;
   logic [AW-1:0]    rd_ptr;
   logic [AW:0]      count;
   logic             do_push;
   logic             do_pop;

   assign empty   = (count == '0);
   assign full    = (count == FULL_CNT);
   assign do_pop  = pop && !empty;
   assign do_push = push && (!full || do_pop);
   assign head    = mem[rd_ptr];

   always_ff @(posedge clk) begin
      if (do_push) mem[wr_ptr] <= push_data;
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         wr_ptr <= '0;
         rd_ptr <= '0;
         count  <= '0;
      end else begin
         if (do_push) wr_ptr <= wr_ptr + AW'(1);
         if (do_pop)  rd_ptr <= rd_ptr + AW'(1);
         case ({do_push, do_pop})
            2'b10:   count <= count + (AW+1)'(1);
            2'b01:   count <= count - (AW+1)'(1);
            default: count <= count;
         endcase
      end
   end
endmodule

// File: rtl/cg_memory_arbiter.sv
// rtl/cg_memory_arbiter.sv - round-robin two-requester memory arbiter with in-order read return
// Optional per-requester grant/stall counters under CG_MEM_ARB_STATS_EN.
module cg_memory_arbiter
   import cg_mem_arb_pkg::*;
#(
   parameter int DATA_WIDTH  = 32,
   parameter int ADDR_WIDTH  = 32,
   parameter int OUTSTANDING = 4
) (
   input  logic                    i_clk,
   input  logic                    i_rst_n,
   input  logic [1:0]              i_req_valid,
   output logic [1:0]              o_req_ready,
   input  logic [1:0]              i_req_wen,
   input  logic [2*ADDR_WIDTH-1:0] i_req_addr,
   input  logic [2*DATA_WIDTH-1:0] i_req_wdata,
   output logic [1:0]              o_rsp_valid,
   input  logic [1:0]              i_rsp_ready,
   output logic [DATA_WIDTH-1:0]   o_rsp_rdata,
   output logic                    o_mem_wen,
   output logic                    o_mem_wdata_valid,
   output logic [ADDR_WIDTH-1:0]   o_mem_waddr,
   output logic [DATA_WIDTH-1:0]   o_mem_wdata,
   input  logic                    i_mem_wdata_ready,
   output logic                    o_mem_raddr_valid,
   output logic [ADDR_WIDTH-1:0]   o_mem_raddr,
   input  logic                    i_mem_raddr_ready,
   input  logic                    i_mem_rdata_valid,
   input  logic [DATA_WIDTH-1:0]   i_mem_rdata,
   output logic                    o_mem_rdata_ready,
   output logic [2*32-1:0]         o_stat_grant,
   output logic [2*32-1:0]         o_stat_stall
);
   arb_state_e state, state_nxt;
   req_id_t    gnt_id, gnt_id_nxt;
   req_id_t    prio, prio_nxt;
   req_id_t    grant_id;
   req_id_t    head_id;
   logic       grant_valid;
   logic       grant_wen;
   logic       accept;
   logic       fifo_full;
   logic       fifo_empty;
   logic       pop;

   always_ff @(posedge i_clk or negedge i_rst_n) begin
      if (!i_rst_n) begin
         state  <= ARB_IDLE;
         gnt_id <= '0;
         prio   <= '0;
      end else begin
         state  <= state_nxt;
         gnt_id <= gnt_id_nxt;
         prio   <= prio_nxt;
      end
   end

   always_comb begin
      state_nxt   = state;
      gnt_id_nxt  = gnt_id;
      prio_nxt    = prio;
      grant_valid = 1'b0;
      grant_id    = gnt_id;
      case (state)
         ARB_IDLE: begin
            if (i_req_valid[prio]) begin
               grant_valid = 1'b1;
               grant_id    = prio;
            end else if (i_req_valid[~prio]) begin
               grant_valid = 1'b1;
               grant_id    = ~prio;
            end
         end
         ARB_HOLD: begin
            grant_valid = i_req_valid[gnt_id];
            grant_id    = gnt_id;
         end
         default: grant_valid = 1'b0;
      endcase
      // Nothing may look valid to the memory while reset is held.
      if (!i_rst_n) grant_valid = 1'b0;
      grant_wen = i_req_wen[grant_id];
      accept    = grant_valid && (grant_wen ? i_mem_wdata_ready
                                            : (i_mem_raddr_ready && (!fifo_full || pop)));
      if (accept) begin
         prio_nxt  = ~grant_id;
         state_nxt = ARB_IDLE;
      end else if (grant_valid) begin
         state_nxt  = ARB_HOLD;
         gnt_id_nxt = grant_id;
      end
   end

   assign o_req_ready       = accept ? (2'b01 << grant_id) : 2'b00;
   assign o_mem_wen         = grant_valid && grant_wen;
   assign o_mem_wdata_valid = grant_valid && grant_wen;
   assign o_mem_raddr_valid = grant_valid && !grant_wen;
   assign o_mem_waddr       = grant_id ? i_req_addr[2*ADDR_WIDTH-1:ADDR_WIDTH] : i_req_addr[ADDR_WIDTH-1:0];
   assign o_mem_raddr       = o_mem_waddr;
   assign o_mem_wdata       = grant_id ? i_req_wdata[2*DATA_WIDTH-1:DATA_WIDTH] : i_req_wdata[DATA_WIDTH-1:0];

   // Read data is routed to whichever requester owns the oldest tag.
   assign o_mem_rdata_ready = i_rst_n && i_rsp_ready[head_id];
   assign pop               = i_mem_rdata_valid && o_mem_rdata_ready && !fifo_empty;
   assign o_rsp_valid       = (i_mem_rdata_valid && !fifo_empty) ? (2'b01 << head_id) : 2'b00;
   assign o_rsp_rdata       = i_mem_rdata;

   cg_mem_arb_tag_fifo #(
      .DEPTH (OUTSTANDING),
      .WIDTH ($bits(req_id_t))
   ) u_tag_fifo (
      .clk       (i_clk),
      .rst_n     (i_rst_n),
      .push      (accept && !grant_wen),
      .push_data (grant_id),
      .pop       (pop),
      .full      (fifo_full),
      .empty     (fifo_empty),
      .head      (head_id)
   );

`ifdef CG_MEM_ARB_STATS_EN
   logic [NUM_REQ-1:0][31:0] stat_grant;
   logic [NUM_REQ-1:0][31:0] stat_stall;

   always_ff @(posedge i_clk or negedge i_rst_n) begin
      if (!i_rst_n) begin
         stat_grant <= '0;
         stat_stall <= '0;
      end else begin
         for (int r = 0; r < NUM_REQ; r++) begin
            if (o_req_ready[r])                    stat_grant[r] <= stat_grant[r] + 32'd1;
            if (i_req_valid[r] && !o_req_ready[r]) stat_stall[r] <= stat_stall[r] + 32'd1;
         end
      end
   end

   assign o_stat_grant = stat_grant;
   assign o_stat_stall = stat_stall;
`else
   assign o_stat_grant = '0;
   assign o_stat_stall = '0;
`endif
endmodule

// File: tb/tb_cg_memory_arbiter.sv
// tb/tb_cg_memory_arbiter.sv - self-checking bench for cg_memory_arbiter
// Expected stat values follow CG_MEM_ARB_STATS_EN.
module tb_cg_memory_arbiter;
   localparam int DW = 32;
   localparam int AW = 32;
   localparam int OUT = 4;

   logic          clk = 1'b0;
   logic          i_rst_n;
   logic [1:0]    i_req_valid, o_req_ready, i_req_wen;
   logic [2*AW-1:0] i_req_addr;
   logic [2*DW-1:0] i_req_wdata;
   logic [1:0]    o_rsp_valid, i_rsp_ready;
   logic [DW-1:0] o_rsp_rdata;
   logic          o_mem_wen, o_mem_wdata_valid, i_mem_wdata_ready;
   logic [AW-1:0] o_mem_waddr, o_mem_raddr;
   logic [DW-1:0] o_mem_wdata, i_mem_rdata;
   logic          o_mem_raddr_valid, i_mem_raddr_ready, i_mem_rdata_valid, o_mem_rdata_ready;
   logic [63:0]   o_stat_grant, o_stat_stall;

   int n_checks = 0;
   int n_fail   = 0;

   wire [7:0] obs = {o_req_ready, o_mem_wen, o_mem_wdata_valid, o_mem_raddr_valid,
                     o_rsp_valid, o_mem_rdata_ready};

   always #5 clk = ~clk;

   cg_memory_arbiter #(.DATA_WIDTH(DW), .ADDR_WIDTH(AW), .OUTSTANDING(OUT)) dut (
      .i_clk(clk), .i_rst_n(i_rst_n),
      .i_req_valid(i_req_valid), .o_req_ready(o_req_ready), .i_req_wen(i_req_wen),
      .i_req_addr(i_req_addr), .i_req_wdata(i_req_wdata),
      .o_rsp_valid(o_rsp_valid), .i_rsp_ready(i_rsp_ready), .o_rsp_rdata(o_rsp_rdata),
      .o_mem_wen(o_mem_wen), .o_mem_wdata_valid(o_mem_wdata_valid), .o_mem_waddr(o_mem_waddr),
      .o_mem_wdata(o_mem_wdata), .i_mem_wdata_ready(i_mem_wdata_ready),
      .o_mem_raddr_valid(o_mem_raddr_valid), .o_mem_raddr(o_mem_raddr),
      .i_mem_raddr_ready(i_mem_raddr_ready), .i_mem_rdata_valid(i_mem_rdata_valid),
      .i_mem_rdata(i_mem_rdata), .o_mem_rdata_ready(o_mem_rdata_ready),
      .o_stat_grant(o_stat_grant), .o_stat_stall(o_stat_stall)
   );

   task automatic clear_inputs();
      i_req_valid = '0; i_req_wen = '0; i_req_addr = '0; i_req_wdata = '0;
      i_rsp_ready = '0; i_mem_wdata_ready = 0; i_mem_raddr_ready = 0;
      i_mem_rdata_valid = 0; i_mem_rdata = '0;
   endtask

   task automatic do_reset();
      i_rst_n = 1'b0;
      clear_inputs();
      @(negedge clk);
      @(negedge clk);
      i_rst_n = 1'b1;
   endtask

   task automatic test_reset();
      i_rst_n = 1'b0;
      i_req_valid = 2'b11; i_mem_raddr_ready = 1; i_mem_wdata_ready = 1;
      i_rsp_ready = 2'b11; i_mem_rdata_valid = 1;
      #1;
      n_checks++;
      if (obs !== 8'h00) begin n_fail++; $display("FAIL reset_outputs got=%h exp=00", obs); end
      n_checks++;
      if ({o_stat_grant, o_stat_stall} !== 128'd0) begin
         n_fail++; $display("FAIL reset_stats got=%h/%h exp=0", o_stat_grant, o_stat_stall);
      end
      do_reset();
   endtask

   task automatic test_in_order();
      logic [33:0] got;
      do_reset();
      i_req_addr = {32'h20, 32'h10}; i_req_valid = 2'b11; i_mem_raddr_ready = 1; i_rsp_ready = 2'b11;
      #1 got = {o_req_ready, o_mem_raddr};
      n_checks++;
      if (got !== {2'b01, 32'h10}) begin n_fail++; $display("FAIL order_grant0 got=%h exp=%h", got, {2'b01, 32'h10}); end
      @(negedge clk); i_req_valid = 2'b10;
      #1 got = {o_req_ready, o_mem_raddr};
      n_checks++;
      if (got !== {2'b10, 32'h20}) begin n_fail++; $display("FAIL order_grant1 got=%h exp=%h", got, {2'b10, 32'h20}); end
      @(negedge clk); i_req_valid = 2'b00; i_mem_rdata_valid = 1; i_mem_rdata = 32'haaaa;
      #1 got = {o_rsp_valid, o_rsp_rdata};
      n_checks++;
      if (got !== {2'b01, 32'haaaa}) begin n_fail++; $display("FAIL order_rsp0 got=%h exp=%h", got, {2'b01, 32'haaaa}); end
      @(negedge clk); i_mem_rdata = 32'hbbbb;
      #1 got = {o_rsp_valid, o_rsp_rdata};
      n_checks++;
      if (got !== {2'b10, 32'hbbbb}) begin n_fail++; $display("FAIL order_rsp1 got=%h exp=%h", got, {2'b10, 32'hbbbb}); end
      @(negedge clk); i_mem_rdata = 32'hcccc;
      #1;
      n_checks++;
      if (o_rsp_valid !== 2'b00) begin n_fail++; $display("FAIL order_drop_empty got=%b exp=00", o_rsp_valid); end
      @(negedge clk); clear_inputs();
   endtask

   task automatic test_alternate();
      int cnt[2];
      logic [1:0] exp;
      cnt[0] = 0; cnt[1] = 0;
      do_reset();
      i_req_wen = 2'b11; i_mem_wdata_ready = 1; i_req_valid = 2'b11;
      i_req_addr = {32'h1111, 32'h0000};
      for (int i = 0; i < 8; i++) begin
         exp = (i % 2 == 1) ? 2'b10 : 2'b01;
         #1;
         n_checks++;
         if (o_req_ready !== exp) begin n_fail++; $display("FAIL alt_grant[%0d] got=%b exp=%b", i, o_req_ready, exp); end
         if (o_req_ready[0]) cnt[0]++;
         if (o_req_ready[1]) cnt[1]++;
         @(negedge clk);
      end
      n_checks++;
      if (cnt[0] != 4 || cnt[1] != 4) begin n_fail++; $display("FAIL alt_counts got=%0d/%0d exp=4/4", cnt[0], cnt[1]); end
      clear_inputs();
   endtask

   task automatic test_hold();
      logic [34:0] got;
      do_reset();
      i_req_wen = 2'b11; i_req_addr = {32'h100, 32'h200}; i_req_valid = 2'b10; i_mem_wdata_ready = 0;
      for (int c = 0; c < 4; c++) begin
         if (c == 1) i_req_valid = 2'b11;
         if (c == 3) i_mem_wdata_ready = 1;
         #1 got = {o_req_ready, o_mem_wen, o_mem_waddr};
         n_checks++;
         if (got !== {(c == 3) ? 2'b10 : 2'b00, 1'b1, 32'h100}) begin
            n_fail++; $display("FAIL hold_cycle%0d got=%h exp_r1_addr=100", c, got);
         end
         @(negedge clk);
      end
      i_req_valid = 2'b01;
      #1 got = {o_req_ready, o_mem_wen, o_mem_waddr};
      n_checks++;
      if (got !== {2'b01, 1'b1, 32'h200}) begin n_fail++; $display("FAIL hold_next_r0 got=%h exp=%h", got, {2'b01, 1'b1, 32'h200}); end
      @(negedge clk); clear_inputs();
   endtask

   task automatic test_full();
      do_reset();
      i_req_valid = 2'b01; i_mem_raddr_ready = 1; i_req_addr = {32'h0, 32'h40};
      for (int i = 0; i < 4; i++) begin
         #1;
         n_checks++;
         if (o_req_ready !== 2'b01) begin n_fail++; $display("FAIL full_fill[%0d] got=%b exp=01", i, o_req_ready); end
         @(negedge clk);
      end
      #1;
      n_checks++;
      if ({o_req_ready, o_mem_raddr_valid} !== 3'b001) begin
         n_fail++; $display("FAIL full_block got=%b exp=001", {o_req_ready, o_mem_raddr_valid});
      end
      @(negedge clk); i_rsp_ready = 2'b01; i_mem_rdata_valid = 1;
      #1;
      n_checks++;
      if ({o_req_ready, o_rsp_valid, o_mem_rdata_ready} !== 5'b01011) begin
         n_fail++; $display("FAIL full_push_pop got=%b exp=01011", {o_req_ready, o_rsp_valid, o_mem_rdata_ready});
      end
      @(negedge clk); i_rsp_ready = 2'b00; i_mem_rdata_valid = 0;
      #1;
      n_checks++;
      if (o_req_ready !== 2'b00) begin n_fail++; $display("FAIL full_still_4 got=%b exp=00", o_req_ready); end
      @(negedge clk); i_req_valid = 2'b00; i_rsp_ready = 2'b01; i_mem_rdata_valid = 1;
      for (int i = 0; i < 5; i++) begin
         #1;
         n_checks++;
         if (o_rsp_valid !== ((i < 4) ? 2'b01 : 2'b00)) begin
            n_fail++; $display("FAIL full_drain[%0d] got=%b exp=%b", i, o_rsp_valid, (i < 4) ? 2'b01 : 2'b00);
         end
         @(negedge clk);
      end
      clear_inputs();
   endtask

   task automatic test_reset_mid();
      do_reset();
      i_req_valid = 2'b01; i_mem_raddr_ready = 1; i_req_addr = {32'h300, 32'h80};
      @(negedge clk); @(negedge clk);
      i_req_valid = 2'b10; i_req_wen = 2'b10; i_mem_wdata_ready = 0;
      @(negedge clk);
      #1;
      n_checks++;
      if ({o_req_ready, o_mem_wen} !== 3'b001) begin n_fail++; $display("FAIL mid_hold got=%b exp=001", {o_req_ready, o_mem_wen}); end
      #1 i_rst_n = 1'b0;
      i_req_valid = 2'b11; i_mem_rdata_valid = 1; i_rsp_ready = 2'b11; i_mem_wdata_ready = 1;
      #1;
      n_checks++;
      if (obs !== 8'h00) begin n_fail++; $display("FAIL mid_reset_outputs got=%h exp=00", obs); end
      @(negedge clk); @(negedge clk);
      i_rst_n = 1'b1; i_req_wen = 2'b00;
      #1;
      n_checks++;
      if ({o_req_ready, o_rsp_valid} !== 4'b0100) begin
         n_fail++; $display("FAIL mid_after_release got=%b exp=0100", {o_req_ready, o_rsp_valid});
      end
      @(negedge clk); clear_inputs();
   endtask

   task automatic test_stats();
      logic [63:0] eg, es;
      do_reset();
      i_req_valid = 2'b01; i_mem_raddr_ready = 0;
      repeat (3) @(negedge clk);
      i_mem_raddr_ready = 1;
      #1;
      n_checks++;
      if (o_req_ready !== 2'b01) begin n_fail++; $display("FAIL stats_accept got=%b exp=01", o_req_ready); end
      @(negedge clk); i_req_valid = 2'b00;
`ifdef CG_MEM_ARB_STATS_EN
      eg = 64'd1; es = 64'd3;
`else
      eg = 64'd0; es = 64'd0;
`endif
      #1;
      n_checks++;
      if (o_stat_grant !== eg) begin n_fail++; $display("FAIL stats_grant got=%h exp=%h", o_stat_grant, eg); end
      n_checks++;
      if (o_stat_stall !== es) begin n_fail++; $display("FAIL stats_stall got=%h exp=%h", o_stat_stall, es); end
      @(negedge clk); clear_inputs();
   endtask

   task automatic test_random();
      logic [31:0] t_addr[2], t_wdata[2];
      logic        t_wen[2], have[2];
      int          qid[$];
      logic [31:0] qaddr[$];
      int          prio_m, owner, g;
      bit          locked, gv, pop_m, acc;
      logic [31:0] gcnt[2], scnt[2];
      logic [1:0]  exp_ready, exp_rsp;
      do_reset();
      for (int r = 0; r < 2; r++) begin
         have[r] = 0; t_wen[r] = 0; t_addr[r] = '0; t_wdata[r] = '0; gcnt[r] = 0; scnt[r] = 0;
      end
      prio_m = 0; owner = 0; locked = 0;
      for (int c = 0; c < 800; c++) begin
         for (int r = 0; r < 2; r++) begin
            if (!have[r] && $urandom_range(0, 1) == 1) begin
               have[r] = 1; t_wen[r] = 1'($urandom_range(0, 1));
               t_addr[r] = $urandom; t_wdata[r] = $urandom;
            end
         end
         i_req_valid = {have[1], have[0]};
         i_req_wen   = {t_wen[1], t_wen[0]};
         i_req_addr  = {t_addr[1], t_addr[0]};
         i_req_wdata = {t_wdata[1], t_wdata[0]};
         i_mem_wdata_ready = ($urandom_range(0, 3) != 0);
         i_mem_raddr_ready = ($urandom_range(0, 3) != 0);
         i_rsp_ready = 2'($urandom_range(0, 3));
         if (qid.size() > 0) begin
            i_mem_rdata_valid = 1'($urandom_range(0, 1));
            i_mem_rdata = qaddr[0] ^ 32'h5a5a_0f0f;
         end else begin
            i_mem_rdata_valid = ($urandom_range(0, 7) == 0);
            i_mem_rdata = $urandom;
         end
         #1;
         gv = 0; g = 0;
         if (locked) begin gv = 1; g = owner; end
         else if (have[prio_m]) begin gv = 1; g = prio_m; end
         else if (have[1 - prio_m]) begin gv = 1; g = 1 - prio_m; end
         pop_m = i_mem_rdata_valid && qid.size() > 0 && i_rsp_ready[qid[0]];
         acc = gv && (t_wen[g] ? i_mem_wdata_ready
                               : (i_mem_raddr_ready && (qid.size() < OUT || pop_m)));
         exp_ready = acc ? 2'(1 << g) : 2'b00;
         exp_rsp = (i_mem_rdata_valid && qid.size() > 0) ? 2'(1 << qid[0]) : 2'b00;
         n_checks++;
         if (o_req_ready !== exp_ready) begin n_fail++; $display("FAIL rnd_ready c=%0d got=%b exp=%b", c, o_req_ready, exp_ready); end
         n_checks++;
         if ({o_mem_wen, o_mem_raddr_valid} !== {gv && t_wen[g], gv && !t_wen[g]}) begin
            n_fail++; $display("FAIL rnd_memvalid c=%0d got=%b exp=%b", c, {o_mem_wen, o_mem_raddr_valid}, {gv && t_wen[g], gv && !t_wen[g]});
         end
         if (gv) begin
            n_checks++;
            if (o_mem_waddr !== t_addr[g] || o_mem_raddr !== t_addr[g] || (t_wen[g] && o_mem_wdata !== t_wdata[g])) begin
               n_fail++; $display("FAIL rnd_payload c=%0d got=%h/%h exp=%h/%h", c, o_mem_waddr, o_mem_wdata, t_addr[g], t_wdata[g]);
            end
         end
         n_checks++;
         if (o_rsp_valid !== exp_rsp) begin n_fail++; $display("FAIL rnd_rsp c=%0d got=%b exp=%b", c, o_rsp_valid, exp_rsp); end
         if (qid.size() > 0) begin
            n_checks++;
            if (o_mem_rdata_ready !== i_rsp_ready[qid[0]] || (i_mem_rdata_valid && o_rsp_rdata !== (qaddr[0] ^ 32'h5a5a_0f0f))) begin
               n_fail++; $display("FAIL rnd_rdata c=%0d got=%b/%h exp=%b/%h", c, o_mem_rdata_ready, o_rsp_rdata, i_rsp_ready[qid[0]], qaddr[0] ^ 32'h5a5a_0f0f);
            end
         end
         for (int r = 0; r < 2; r++) begin
            if (exp_ready[r]) gcnt[r]++;
            if (have[r] && !exp_ready[r]) scnt[r]++;
         end
         if (pop_m) begin void'(qid.pop_front()); void'(qaddr.pop_front()); end
         if (acc) begin
            if (!t_wen[g]) begin qid.push_back(g); qaddr.push_back(t_addr[g]); end
            have[g] = 0; prio_m = 1 - g; locked = 0;
         end else if (gv) begin
            locked = 1; owner = g;
         end
         @(negedge clk);
      end
      clear_inputs();
      #1;
`ifndef CG_MEM_ARB_STATS_EN
      for (int r = 0; r < 2; r++) begin gcnt[r] = 0; scnt[r] = 0; end
`endif
      n_checks++;
      if (o_stat_grant !== {gcnt[1], gcnt[0]} || o_stat_stall !== {scnt[1], scnt[0]}) begin
         n_fail++; $display("FAIL rnd_stats got=%h/%h exp=%h/%h", o_stat_grant, o_stat_stall, {gcnt[1], gcnt[0]}, {scnt[1], scnt[0]});
      end
      @(negedge clk);
   endtask

   initial begin
      i_rst_n = 1'b0;
      clear_inputs();
      @(negedge clk);
      test_reset();
      test_in_order();
      test_alternate();
      test_hold();
      test_full();
      test_reset_mid();
      test_stats();
      test_random();
      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end
endmodule
